// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : Execute-stage ALU (add/sub/and/or) with valid/ready handshake
//               and a 2-entry result buffer so writeback/branch backpressure
//               never drops an operation. Flags unsupported control codes and
//               keeps a saturating count of them.
//               Optional macro ALU_EXEC_SLT_EN enables code 0111 (signed
//               set-less-than); otherwise 0111 is treated as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   // ALU control encodings produced by the ALU control decoder
   localparam logic [3:0] C_OP_AND = 4'b0000;
   localparam logic [3:0] C_OP_OR  = 4'b0001;
   localparam logic [3:0] C_OP_ADD = 4'b0010;
   localparam logic [3:0] C_OP_SUB = 4'b0110;
`ifdef ALU_EXEC_SLT_EN
   localparam logic [3:0] C_OP_SLT = 4'b0111;
`endif

   localparam logic [1:0]       C_DEPTH   = 2'd2;
   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

   // Combinational ALU outputs for the operation currently offered
   logic [WIDTH-1:0] w_res;
   logic             w_zero;
   logic             w_ill;

   // Handshake qualifiers
   logic             w_push;
   logic             w_pop;

   // Two-entry circular buffer, head selected by r_rd_ptr
   logic [WIDTH-1:0] r_res  [2];
   logic             r_zero [2];
   logic             r_ill  [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic [CNT_W-1:0] r_ill_cnt;

   // ALU datapath: pure function of the offered operation; unsupported codes
   // produce a zero result marked illegal
   always_comb begin
      w_res = '0;
      w_ill = 1'b0;
      case (alu_ctrl)
         C_OP_ADD: w_res = op_a + op_b;
         C_OP_SUB: w_res = op_a - op_b;
         C_OP_AND: w_res = op_a & op_b;
         C_OP_OR:  w_res = op_a | op_b;
`ifdef ALU_EXEC_SLT_EN
         C_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`endif
         default:  w_ill = 1'b1;
      endcase
   end

   // Zero flag follows the stored result, but an illegal entry never reports zero
   assign w_zero = ~w_ill & (w_res == '0);

   // Ready depends on occupancy only, so out_ready never reaches in_ready
   assign in_ready  = (r_count < C_DEPTH);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   // Head entry drives the outputs; it holds while stalled and keeps its last
   // value once the buffer drains
   assign result      = r_res[r_rd_ptr];
   assign zero        = r_zero[r_rd_ptr];
   assign illegal     = r_ill[r_rd_ptr];
   assign illegal_cnt = r_ill_cnt;

   // Buffer storage: write the new result into the tail slot on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res[0]  <= '0;
         r_res[1]  <= '0;
         r_zero[0] <= 1'b0;
         r_zero[1] <= 1'b0;
         r_ill[0]  <= 1'b0;
         r_ill[1]  <= 1'b0;
      end else if (w_push) begin
         r_res[r_wr_ptr]  <= w_res;
         r_zero[r_wr_ptr] <= w_zero;
         r_ill[r_wr_ptr]  <= w_ill;
      end
   end

   // Pointer and occupancy bookkeeping; push+pop at count 1 keeps count at 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Saturating count of accepted illegal operations
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ill_cnt <= '0;
      end else if (w_push && w_ill && (r_ill_cnt != C_CNT_MAX)) begin
         r_ill_cnt <= r_ill_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_stage
// Description : Scoreboard bench for alu_exec_stage. The driver pushes the
//               hand-computed expected entry when an operation is accepted;
//               an independent monitor pops and compares on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

   localparam int WIDTH = 64;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;
   logic [CNT_W-1:0] illegal_cnt;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             z;
      logic             ill;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   alu_exec_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_ctrl    (alu_ctrl),
      .op_a        (op_a),
      .op_b        (op_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .illegal     (illegal),
      .illegal_cnt (illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Monitor: compare the head entry against the scoreboard on each handshake
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got result %0h with empty scoreboard", result);
         end else begin
            e = sb.pop_front();
            chk("result",  result,  e.res);
            chk("zero",    {63'd0, zero},    {63'd0, e.z});
            chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
         end
      end
   end

   // Offer one operation; expected entry is queued at the accepting edge
   task automatic send(input logic [3:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] er, input logic ez, input logic ei);
      exp_t e;
      bit   done;
      done     = 1'b0;
      alu_ctrl = c;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            e.res = er;
            e.z   = ez;
            e.ill = ei;
            sb.push_back(e);
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got in_ready stuck low want accept within 50 cycles");
      end
   endtask

   // Wait for the buffer and scoreboard to empty, bounded
   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && out_valid === 1'b0) ok = 1'b1;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      alu_ctrl  = 4'b0000;
      op_a      = '0;
      op_b      = '0;
      out_ready = 1'b1;
      #12;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset state
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
      chk("rst_result",    result,             64'd0);
      chk("rst_zero",      {63'd0, zero},      64'd0);
      chk("rst_illegal",   {63'd0, illegal},   64'd0);
      chk("rst_cnt",       {56'd0, illegal_cnt}, 64'd0);

      // Basic ops with one-cycle latency
      send(4'b0010, 64'd5,    64'd3,    64'd8,    1'b0, 1'b0);
      chk("lat_add", {63'd0, out_valid}, 64'd1);
      send(4'b0110, 64'd7,    64'd7,    64'd0,    1'b1, 1'b0);
      chk("lat_sub", {63'd0, out_valid}, 64'd1);
      send(4'b0000, 64'hF0,   64'h3C,   64'h30,   1'b0, 1'b0);
      chk("lat_and", {63'd0, out_valid}, 64'd1);
      send(4'b0001, 64'hF0,   64'h0F,   64'hFF,   1'b0, 1'b0);
      chk("lat_or",  {63'd0, out_valid}, 64'd1);
      drain();

      // Wraparound
      send(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);
      send(4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      drain();

      // Backpressure: third op must wait for space
      out_ready = 1'b0;
      send(4'b0010, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0);
      send(4'b0010, 64'd2, 64'd2, 64'd4, 1'b0, 1'b0);
      alu_ctrl = 4'b0010;
      op_a     = 64'd3;
      op_b     = 64'd3;
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_result",  result, 64'd2);
      @(posedge clk);
      #1;
      chk("bp_hold_valid",   {63'd0, out_valid}, 64'd1);
      chk("bp_hold_result2", result, 64'd2);
      out_ready = 1'b1;
      send(4'b0010, 64'd3, 64'd3, 64'd6, 1'b0, 1'b0);
      drain();

      // Simultaneous push/pop at occupancy 1
      send(4'b0010, 64'd10, 64'd1, 64'd11, 1'b0, 1'b0);
      send(4'b0010, 64'd20, 64'd2, 64'd22, 1'b0, 1'b0);
      chk("pp_in_ready1",  {63'd0, in_ready},  64'd1);
      chk("pp_out_valid1", {63'd0, out_valid}, 64'd1);
      send(4'b0010, 64'd30, 64'd3, 64'd33, 1'b0, 1'b0);
      chk("pp_in_ready2",  {63'd0, in_ready},  64'd1);
      chk("pp_out_valid2", {63'd0, out_valid}, 64'd1);
      send(4'b0010, 64'd40, 64'd4, 64'd44, 1'b0, 1'b0);
      chk("pp_in_ready3",  {63'd0, in_ready},  64'd1);
      chk("pp_result3",    result, 64'd44);
      drain();

      // Illegal codes
      send(4'b1111, 64'd5, 64'd3, 64'd0, 1'b0, 1'b1);
      drain();
      chk("ill_cnt1", {56'd0, illegal_cnt}, 64'd1);
`ifdef ALU_EXEC_SLT_EN
      send(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0);
      drain();
      chk("ill_cnt_slt", {56'd0, illegal_cnt}, 64'd1);
`else
      send(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1);
      drain();
      chk("ill_cnt_slt", {56'd0, illegal_cnt}, 64'd2);
`endif

      // Counter saturation
      for (int i = 0; i < 260; i++) begin
         send(4'b1000, 64'(i), 64'd1, 64'd0, 1'b0, 1'b1);
      end
      drain();
      chk("ill_cnt_sat", {56'd0, illegal_cnt}, 64'd255);

      // Reset with two entries buffered
      out_ready = 1'b0;
      send(4'b0010, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0);
      send(4'b0010, 64'd4, 64'd5, 64'd9, 1'b0, 1'b0);
      chk("full_in_ready", {63'd0, in_ready}, 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_cnt",       {56'd0, illegal_cnt}, 64'd0);
      chk("arst_result",    result, 64'd0);
      sb.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready",  {63'd0, in_ready},  64'd1);
      chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      out_ready = 1'b1;
      send(4'b0010, 64'd6, 64'd7, 64'd13, 1'b0, 1'b0);
      drain();

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
